eth_vlg_udp_pktzr: RTL and testbench

Upstream UDP packetizer for the eth_vlg core's raw UDP transmit port. It accepts an unframed user byte stream, buffers it in an internal FIFO and cuts it into UDP payloads. A payload is cut when it reaches the maximum size, when the stream goes idle, or on an explicit flush. It drives `udp_len`/`udp_din`/`udp_vin` and honours `udp_cts`.

---
 rtl/eth_vlg_udp_pktzr_if.sv | 24 ++
 rtl/eth_vlg_udp_pktzr.sv | 108 ++++++++++
 tb/tb_eth_vlg_udp_pktzr.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_vlg_udp_pktzr_if.sv
// User byte stream and raw UDP transmit port of the packetizer.
// The slave modport is the packetizer side; master is the user/core side.
interface eth_vlg_udp_pktzr_if;
  logic [7:0]  s_dat;
  logic        s_val;
  logic        s_rdy;
  logic        s_flush;
  logic        ready;
  logic [15:0] udp_len;
  logic [7:0]  udp_din;
  logic        udp_vin;
  logic        udp_cts;
  logic [15:0] pkt_cnt;

  modport slave (
    input  s_dat, s_val, s_flush, ready, udp_cts,
    output s_rdy, udp_len, udp_din, udp_vin, pkt_cnt
  );

  modport master (
    output s_dat, s_val, s_flush, ready, udp_cts,
    input  s_rdy, udp_len, udp_din, udp_vin, pkt_cnt
  );
endinterface

// File: rtl/eth_vlg_udp_pktzr.sv
// Buffers an unframed user byte stream and cuts it into UDP payloads
// on size, idle timeout or explicit flush.
module eth_vlg_udp_pktzr #(
  parameter int MAX_LEN     = 1024,
  parameter int FIFO_DEPTH  = 11,
  parameter int FLUSH_TICKS = 125
) (
  input  logic               clk,
  input  logic               rst,
  eth_vlg_udp_pktzr_if.slave io
);
  localparam int PW = FIFO_DEPTH + 1;
  localparam int TW = $clog2(FLUSH_TICKS + 1);
  localparam logic [PW-1:0] FULL = PW'(2**FIFO_DEPTH);
  localparam logic [PW-1:0] MAXL = PW'(MAX_LEN);
  localparam logic [TW-1:0] TMAX = TW'(FLUSH_TICKS);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  logic [7:0]            r_mem [0:2**FIFO_DEPTH-1];
  logic [FIFO_DEPTH-1:0] r_wptr, r_rptr;
  logic [PW-1:0]         r_pending, r_rem;
  logic [TW-1:0]         r_timer;
  logic                  r_flush;
  state_t                r_state;
  logic [15:0]           r_len, r_pkt_cnt;
  logic [7:0]            r_dout;
  logic                  r_vin;

  logic          w_rdy, w_wr, w_rd, w_timeout, w_trig;
  logic [PW-1:0] w_ld_len;

  assign w_rdy     = !rst && (r_pending != FULL);
  assign w_wr      = io.s_val && w_rdy;
  // Reads: first byte in LOAD, then a prefetch per consumed byte except the last.
  assign w_rd      = (r_state == LOAD) ||
                     (r_state == SEND && io.udp_cts && r_rem > PW'(1));
  assign w_timeout = (r_timer == TMAX) && (r_pending != '0);
  assign w_trig    = io.ready && (r_pending != '0) &&
                     ((r_pending >= MAXL) || w_timeout || r_flush);
  assign w_ld_len  = (r_pending > MAXL) ? MAXL : r_pending;

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= io.s_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= '0;
      r_rem     <= '0;
      r_timer   <= '0;
      r_flush   <= 1'b0;
      r_state   <= IDLE;
      r_len     <= '0;
      r_pkt_cnt <= '0;
      r_dout    <= '0;
      r_vin     <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: ;
      endcase

      if (w_wr)                 r_timer <= '0;
      else if (r_timer != TMAX) r_timer <= r_timer + 1'b1;

      // A flush landing on the LOAD entry survives to cover the remainder.
      if (io.s_flush && r_pending != '0)   r_flush <= 1'b1;
      else if (r_state == IDLE && w_trig)  r_flush <= 1'b0;

      case (r_state)
        IDLE: if (w_trig) r_state <= LOAD;
        LOAD: begin
          r_len   <= 16'(w_ld_len);
          r_rem   <= w_ld_len;
          r_dout  <= r_mem[r_rptr];
          r_vin   <= 1'b1;
          r_state <= SEND;
        end
        SEND: if (io.udp_cts) begin
          if (r_rem > PW'(1)) begin
            r_dout <= r_mem[r_rptr];
            r_rem  <= r_rem - 1'b1;
          end else begin
            r_rem   <= '0;
            r_vin   <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.s_rdy   = w_rdy;
  assign io.udp_len = r_len;
  assign io.udp_din = r_dout;
  assign io.udp_vin = r_vin;
  assign io.pkt_cnt = r_pkt_cnt;
endmodule

// File: tb/tb_eth_vlg_udp_pktzr.sv
// Directed and randomized bench for the UDP packetizer: a byte-queue
// scoreboard checks every consumed byte, packet lengths and timing.
module tb_eth_vlg_udp_pktzr;
  localparam int MAX_LEN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  eth_vlg_udp_pktzr_if bus();

  eth_vlg_udp_pktzr #(.MAX_LEN(MAX_LEN), .FIFO_DEPTH(11), .FLUSH_TICKS(125)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q[$];
  int lens[$];
  int n_pkts = 0, pkt_model = 0, vin_cycles = 0;
  bit in_pkt = 0, prev_hold = 0;
  logic [7:0] prev_din;
  int cur_len, cur_cnt, cur_vcyc, last_vcyc, first_cyc, last_wr_cyc, flush_cyc;
  int cts_mode = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0; prev_hold = 0; pkt_model = 0;
      q.delete();
    end else begin
      if (bus.s_val && bus.s_rdy) begin
        q.push_back(bus.s_dat);
        last_wr_cyc = cyc + 1;
      end
      if (bus.s_flush) flush_cyc = cyc + 1;
      if (prev_hold) begin
        chk("hold_vin", bus.udp_vin, 1);
        chk("hold_din", bus.udp_din, prev_din);
      end
      if (bus.udp_vin) begin
        vin_cycles++;
        if (!in_pkt) begin
          in_pkt = 1; cur_len = bus.udp_len; cur_cnt = 0; cur_vcyc = 0; first_cyc = cyc;
        end else chk("len_stable", bus.udp_len, cur_len);
        cur_vcyc++;
        if (bus.udp_cts) begin
          chk("data", bus.udp_din, (q.size() != 0) ? 32'(q.pop_front()) : 32'h100);
          cur_cnt++;
        end
        prev_hold = !bus.udp_cts;
        prev_din  = bus.udp_din;
      end else begin
        prev_hold = 0;
        if (in_pkt) begin
          in_pkt = 0;
          chk("pkt_bytes", cur_cnt, cur_len);
          chk("len_le_max", cur_len <= MAX_LEN, 1);
          lens.push_back(cur_len);
          last_vcyc = cur_vcyc;
          n_pkts++; pkt_model++;
        end
      end
    end
  end

  initial begin
    bus.udp_cts = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (cts_mode)
        0:       bus.udp_cts = 1'b1;
        1:       bus.udp_cts = ~bus.udp_cts;
        default: bus.udp_cts = 1'($urandom);
      endcase
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(int n, bit rnd);
    bit ok;
    int g;
    for (int i = 0; i < n; i++) begin
      bus.s_dat = rnd ? 8'($urandom) : 8'(i);
      bus.s_val = 1'b1;
      g = 0;
      do begin ok = bus.s_rdy; tick(); g++; end while (!ok && g < 5000);
      if (!ok) chk("wr_timeout", ok, 1);
    end
    bus.s_val = 1'b0;
  endtask

  task automatic flush();
    bus.s_flush = 1'b1; tick(); bus.s_flush = 1'b0;
  endtask

  task automatic wait_pkts(int target, int budget);
    int g = 0;
    while (n_pkts < target && g < budget) begin tick(); g++; end
    chk("pkt_wait", n_pkts >= target, 1);
  endtask

  initial begin
    int base, acc, g, vb;
    bus.s_dat = '0; bus.s_val = 1'b0; bus.s_flush = 1'b0; bus.ready = 1'b1;
    tick(3);
    chk("rst_s_rdy", bus.s_rdy, 0);
    chk("rst_len", bus.udp_len, 0);
    chk("rst_din", bus.udp_din, 0);
    chk("rst_vin", bus.udp_vin, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_s_rdy", bus.s_rdy, 1);

    // 1024-byte pattern, contiguous send
    base = n_pkts;
    wr(1024, 0);
    wait_pkts(base + 1, 3000);
    chk("t1_len", lens[$], 1024);
    chk("t1_contig", last_vcyc, 1024);
    tick(3);
    chk("t1_pkt_cnt", bus.pkt_cnt, 1);

    // idle timeout
    base = n_pkts;
    wr(10, 1);
    wait_pkts(base + 1, 400);
    chk("t2_len", lens[$], 10);
    chk("t2_latency", first_cyc - last_wr_cyc, 127);

    // explicit flush
    tick(3);
    base = n_pkts;
    wr(3, 1);
    flush();
    wait_pkts(base + 1, 100);
    chk("t3_len", lens[$], 3);
    chk("t3_latency", first_cyc - flush_cyc, 2);

    // backpressure toggling every cycle
    tick(3);
    cts_mode = 1;
    base = n_pkts;
    wr(1500, 1);
    wait_pkts(base + 2, 6000);
    chk("t4_len0", lens[lens.size()-2], 1024);
    chk("t4_len1", lens[lens.size()-1], 476);
    cts_mode = 0;

    // fill with core not ready
    tick(3);
    bus.ready = 1'b0;
    vb = vin_cycles;
    bus.s_val = 1'b1; acc = 0; g = 0;
    while (bus.s_rdy && g < 3000) begin bus.s_dat = 8'($urandom); tick(); acc++; g++; end
    bus.s_val = 1'b0;
    chk("t5_fill", acc, 2048);
    tick(200);
    chk("t5_no_vin", vin_cycles, vb);
    base = n_pkts;
    bus.ready = 1'b1;
    wait_pkts(base + 2, 5000);
    chk("t5_len0", lens[lens.size()-2], 1024);
    chk("t5_len1", lens[lens.size()-1], 1024);

    // reset mid-packet
    tick(3);
    wr(1024, 1);
    g = 0;
    while (!(in_pkt && cur_cnt >= 500) && g < 3000) begin tick(); g++; end
    chk("t6_midpkt", in_pkt, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("t6_vin", bus.udp_vin, 0);
    chk("t6_pkt_cnt", bus.pkt_cnt, 0);
    chk("t6_s_rdy", bus.s_rdy, 1);
    tick(2);
    base = n_pkts;
    wr(5, 1);
    flush();
    wait_pkts(base + 1, 100);
    chk("t6_len", lens[$], 5);
    tick(3);
    chk("t6_pkt_cnt_after", bus.pkt_cnt, 1);

    // randomized bursts, gaps, flushes and backpressure
    cts_mode = 2;
    for (int b = 0; b < 8; b++) begin
      wr(int'($urandom_range(1, 300)), 1);
      if ($urandom_range(0, 2) == 0) flush();
      tick(int'($urandom_range(0, 200)));
    end
    g = 0;
    while ((q.size() != 0 || in_pkt) && g < 20000) begin tick(); g++; end
    chk("t7_drain", q.size(), 0);
    tick(5);
    chk("t7_pkt_cnt", bus.pkt_cnt, 16'(pkt_model));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
